// File: rtl/param_div.sv
// Iterative radix-2 restoring divider, signed or unsigned, one quotient bit per cycle.
// Valid/ready on both sides, plus flush and a defined divide-by-zero result.
module param_div #(
   parameter int WIDTH = 32
) (
   input  logic             div_clk,
   input  logic             resetn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             div_signed,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic [WIDTH-1:0] r,
   output logic             div_by_zero
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] dvd;     // dividend magnitude; quotient bits shift in from the LSB
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] dvs;
   logic             q_neg, r_neg, zero;

   logic [WIDTH:0]   part;
   logic [WIDTH-1:0] diff, q_mag, r_mag;
   logic             ge, accept, last;

   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sg);
      return (sg && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
   endfunction

   function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
      return neg ? (~v + WIDTH'(1)) : v;
   endfunction

   assign in_ready  = resetn && (state == IDLE);
   assign out_valid = (state == DONE);
   assign accept    = in_valid && in_ready && !flush;
   // A zero divisor spends exactly one cycle in CALC so its result timing is fixed.
   assign last      = (state == CALC) && (zero || (cnt == LAST));

   // The true difference is below 2^WIDTH whenever it is used, so the top bit is dropped.
   always_comb begin
      part  = {rem, dvd[WIDTH-1]};
      ge    = (part >= {1'b0, dvs});
      diff  = part[WIDTH-1:0] - dvs;
      r_mag = ge ? diff : part[WIDTH-1:0];
      q_mag = {dvd[WIDTH-2:0], ge};
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = CALC;
         CALC: begin
            if (flush)     state_nxt = IDLE;
            else if (last) state_nxt = DONE;
         end
         DONE: if (flush || out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge div_clk) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   always_ff @(posedge div_clk) begin
      if (!resetn) begin
         cnt         <= '0;
         s           <= '0;
         r           <= '0;
         div_by_zero <= 1'b0;
      end else begin
         if (accept)              cnt <= '0;
         else if (state == CALC)  cnt <= cnt + CNT_W'(1);
         if (last && !flush) begin
            if (zero) begin
               s           <= '1;
               r           <= dvd;
               div_by_zero <= 1'b1;
            end else begin
               s           <= apply_sign(q_mag, q_neg);
               r           <= apply_sign(r_mag, r_neg);
               div_by_zero <= 1'b0;
            end
         end
      end
   end

   // Datapath registers carry no reset; they are always loaded on acceptance.
   always_ff @(posedge div_clk) begin
      if (accept) begin
         zero  <= (y == '0);
         dvd   <= (y == '0) ? x : magnitude(x, div_signed);
         dvs   <= magnitude(y, div_signed);
         rem   <= '0;
         q_neg <= div_signed && (x[WIDTH-1] ^ y[WIDTH-1]);
         r_neg <= div_signed && x[WIDTH-1];
      end else if (state == CALC) begin
         dvd <= q_mag;
         rem <= r_mag;
      end
   end

endmodule

// File: tb/tb_param_div.sv
// Scoreboard bench for param_div at WIDTH=32: directed corner cases, latency,
// backpressure, flush, reset and a block of random operations.
module tb_param_div;

   logic        div_clk = 1'b0;
   logic        resetn;
   logic        in_valid;
   logic        in_ready;
   logic        div_signed;
   logic [31:0] x;
   logic [31:0] y;
   logic        flush;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] s;
   logic [31:0] r;
   logic        div_by_zero;

   typedef struct {
      logic [31:0] s;
      logic [31:0] r;
      logic        dbz;
   } exp_t;

   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_err  = 0;
   int   n_push = 0;
   int   n_out  = 0;
   int   rdy_mode = 0;   // 0: ready high, 1: ready low, 2: random

   param_div #(.WIDTH(32)) dut (
      .div_clk    (div_clk),
      .resetn     (resetn),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .div_signed (div_signed),
      .x          (x),
      .y          (y),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .s          (s),
      .r          (r),
      .div_by_zero(div_by_zero)
   );

   always #5 div_clk = ~div_clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_cmp++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, expv);
      end
   endtask

   function automatic exp_t model(input logic sg, input logic [31:0] a, input logic [31:0] b);
      exp_t   e;
      longint sa, sbv;
      if (b == 32'd0) begin
         e.s = 32'hFFFF_FFFF; e.r = a; e.dbz = 1'b1;
      end else if (sg) begin
         sa  = longint'($signed(a));
         sbv = longint'($signed(b));
         e.s = 32'(sa / sbv); e.r = 32'(sa % sbv); e.dbz = 1'b0;
      end else begin
         e.s = a / b; e.r = a % b; e.dbz = 1'b0;
      end
      return e;
   endfunction

   always @(posedge div_clk) begin
      #2;
      case (rdy_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'b0;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   always @(negedge div_clk) begin
      if (resetn && out_valid && out_ready && !flush) begin
         if (sb.size() == 0) begin
            check("extra_result", 64'(out_valid), 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("s", 64'(s), 64'(e.s));
            check("r", 64'(r), 64'(e.r));
            check("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
            n_out++;
         end
      end
   end

   task automatic tick();
      @(posedge div_clk);
      #1;
   endtask

   // Returns one time unit after the handshake edge.
   task automatic issue(input logic sg, input logic [31:0] a, input logic [31:0] b,
                        input exp_t e, input bit push);
      int n = 0;
      div_signed = sg; x = a; y = b; in_valid = 1'b1;
      while (!in_ready && n < 200) begin
         tick();
         n++;
      end
      if (!in_ready) begin
         check("issue_timeout", 64'(in_ready), 64'd1);
      end else begin
         if (push) begin
            sb.push_back(e);
            n_push++;
         end
         tick();
      end
      in_valid   = 1'b0;
      x          = $urandom;
      y          = $urandom;
      div_signed = 1'($urandom_range(0, 1));
   endtask

   task automatic run_one(input string tag, input logic sg, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] es, input logic [31:0] er,
                          input logic ed, input int lat_exp);
      exp_t e;
      int   lat = 1;
      e.s = es; e.r = er; e.dbz = ed;
      issue(sg, a, b, e, 1'b1);
      while (!out_valid && lat < 100) begin
         tick();
         lat++;
      end
      check({tag, "_latency"}, 64'(lat), 64'(lat_exp));
      tick();
      check({tag, "_in_ready_after"}, 64'(in_ready), 64'd1);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 2000) begin
         tick();
         n++;
      end
      check("drain", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t        e;
      logic [31:0] cs, cr, a, b;
      logic        sg, seen;
      int          n;

      resetn = 1'b0; in_valid = 1'b0; flush = 1'b0;
      div_signed = 1'b0; x = '0; y = '0;
      repeat (3) tick();
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_s", 64'(s), 64'd0);
      check("rst_r", 64'(r), 64'd0);
      check("rst_dbz", 64'(div_by_zero), 64'd0);
      resetn = 1'b1;
      tick();
      check("idle_in_ready", 64'(in_ready), 64'd1);

      run_one("unsigned", 1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 1'b0, 33);
      run_one("s_pp", 1'b1, 32'd7, 32'd2, 32'd3, 32'd1, 1'b0, 33);
      run_one("s_np", 1'b1, -32'sd7, 32'd2, -32'sd3, -32'sd1, 1'b0, 33);
      run_one("s_pn", 1'b1, 32'd7, -32'sd2, -32'sd3, 32'd1, 1'b0, 33);
      run_one("s_nn", 1'b1, -32'sd7, -32'sd2, 32'd3, -32'sd1, 1'b0, 33);
      run_one("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33);
      run_one("dbz_u", 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 2);
      run_one("dbz_s", 1'b1, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 2);
      drain();

      // Backpressure: result must hold while inputs wander.
      rdy_mode = 1;
      e.s = 32'd14; e.r = 32'd2; e.dbz = 1'b0;
      issue(1'b0, 32'd100, 32'd7, e, 1'b1);
      n = 0;
      while (!out_valid && n < 100) begin
         tick();
         n++;
      end
      cs = s; cr = r;
      check("stall_first_s", 64'(cs), 64'd14);
      repeat (20) begin
         x = $urandom; y = $urandom; div_signed = 1'($urandom_range(0, 1));
         tick();
         check("stall_valid", 64'(out_valid), 64'd1);
         check("stall_s", 64'(s), 64'(cs));
         check("stall_r", 64'(r), 64'(cr));
      end
      rdy_mode = 0;
      drain();

      // Flush at iteration 10 of CALC.
      issue(1'b0, $urandom, 32'd3, e, 1'b0);
      repeat (10) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_in_ready", 64'(in_ready), 64'd1);
      check("flush_out_valid", 64'(out_valid), 64'd0);
      seen = 1'b0;
      repeat (40) begin
         tick();
         seen = seen | out_valid;
      end
      check("flush_no_result", 64'(seen), 64'd0);
      run_one("after_flush", 1'b1, -32'sd100, 32'd9, -32'sd11, -32'sd1, 1'b0, 33);

      // Flush while a result waits in DONE.
      rdy_mode = 1;
      issue(1'b0, 32'd5, 32'd2, e, 1'b0);
      n = 0;
      while (!out_valid && n < 100) begin
         tick();
         n++;
      end
      check("done_valid", 64'(out_valid), 64'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("done_flush_valid", 64'(out_valid), 64'd0);
      check("done_flush_in_ready", 64'(in_ready), 64'd1);
      rdy_mode = 0;
      tick();

      // Reset in the middle of CALC.
      issue(1'b1, $urandom, 32'd5, e, 1'b0);
      repeat (10) tick();
      resetn = 1'b0;
      tick();
      check("mid_rst_out_valid", 64'(out_valid), 64'd0);
      check("mid_rst_s", 64'(s), 64'd0);
      check("mid_rst_r", 64'(r), 64'd0);
      check("mid_rst_dbz", 64'(div_by_zero), 64'd0);
      check("mid_rst_in_ready", 64'(in_ready), 64'd0);
      tick();
      check("mid_rst_in_ready_2", 64'(in_ready), 64'd0);
      resetn = 1'b1;
      tick();
      check("post_rst_in_ready", 64'(in_ready), 64'd1);

      // Random operations with random gaps and random backpressure.
      rdy_mode = 2;
      repeat (200) begin
         sg = 1'($urandom_range(0, 1));
         a  = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : $urandom;
         case ($urandom_range(0, 7))
            0:       b = 32'd0;
            1:       b = 32'hFFFF_FFFF;
            2:       b = $urandom_range(1, 15);
            default: b = $urandom;
         endcase
         issue(sg, a, b, model(sg, a, b), 1'b1);
         repeat ($urandom_range(0, 3)) tick();
      end
      rdy_mode = 0;
      drain();
      check("result_count", 64'(n_out), 64'(n_push));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
